loop_seq_ctrl: RTL
==================

LOOP_SEQ_CTRL -- requirements
Module: loop_seq_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 26: width of the step-delay counter.
REQ-002 SHALL have parameter BASE_DELAY, default 50000000: step period in clk cycles at speed level 0; BASE_DELAY >> (NUM_SPEEDS-1) SHALL be >= 1.
REQ-003 SHALL have parameter NUM_SPEEDS, default 3: number of speed levels, minimum 2.
REQ-004 SHALL have parameter NUM_COLORS, default 4: number of color indices, minimum 2.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port go, input, 1 bit: single-step request, level.
REQ-008 SHALL have port loop_btn, input, 1 bit: loop toggle button, level, press = 1.
REQ-009 SHALL have port speed_btn, input, 1 bit: speed-cycle button, level.
REQ-010 SHALL have port simgo, output, 1 bit: simulation step strobe.
REQ-011 SHALL have port clr, output, 1 bit: equal to simgo.
REQ-012 SHALL have port strtcnt, output, 1 bit: high while state is RUN.
REQ-013 SHALL have port changecolor, output, 1 bit: one-cycle pulse at step-period expiry in RUN.
REQ-014 SHALL have port color_idx, output, clog2(NUM_COLORS) bits: current color index.
REQ-015 SHALL have port speedlvl, output, max(1,clog2(NUM_SPEEDS)) bits: current speed level.
REQ-016 SHALL have port led, output, 3 bits: debug indicators.

Function
REQ-017 SHALL implement FSM states IDLE, ARM, RUN, DISARM.
- IDLE->ARM on loop_btn=1.
- ARM->RUN on loop_btn=0.
- RUN->DISARM on loop_btn=1.
- DISARM->IDLE on loop_btn=0.
- Otherwise hold state; any unused encoding goes to IDLE.
REQ-018 SHALL compute terminal count tc = BASE_DELAY >> speedlvl, in CNT_W bits.
REQ-019 SHALL increment cnt in RUN only; on cnt==tc-1, cnt SHALL go to 0; outside RUN, cnt SHALL be 0.
REQ-020 SHALL assert changecolor combinationally when state==RUN and cnt==tc-1; the first pulse comes in the tc-th RUN cycle, then every tc cycles.
REQ-021 SHALL increment color_idx on each changecolor, wrapping from NUM_COLORS-1 to 0; color_idx SHALL hold in all other states.
REQ-022 SHALL define simgo = changecolor OR go OR (state==IDLE AND loop_btn); go is honoured in every state but does not change color.
REQ-023 SHALL detect speed_btn rising edges against a registered copy; each edge advances speedlvl, wrapping from NUM_SPEEDS-1 to 0, and clears cnt to 0.
REQ-024 SHALL handle a speed edge and terminal count in the same cycle as follows: changecolor asserts using the old tc, cnt goes to 0, and speedlvl advances.
REQ-025 SHALL update speedlvl on speed_btn edges in any state.
REQ-026 SHALL assert strtcnt exactly when state==RUN.

Reset
REQ-027 SHALL, on reset=1 at a clk edge, set state=IDLE, cnt=0, speedlvl=0, color_idx=0, and registered speed_btn=0; reset dominates all other inputs.
REQ-028 SHALL, after reset, drive strtcnt=0, changecolor=0, and led=0; simgo and clr follow go and loop_btn combinationally.
REQ-029 SHALL, on reset mid-RUN, abandon the pending step, so that no changecolor occurs in the cycle after reset.

Configuration
REQ-030 SHALL use macro LOOP_SEQ_DEBUG_LED_EN; when defined, led[0] = (state==RUN), led[1] = changecolor, and led[2] = simgo.
REQ-031 SHALL, when LOOP_SEQ_DEBUG_LED_EN is undefined, tie led to 3'b000 and leave all other behaviour identical.

Verification (BASE_DELAY=8, NUM_SPEEDS=3, NUM_COLORS=4)
REQ-032 SHALL cover: loop_btn pressed 3 cycles from IDLE, then released -> simgo high on the first press cycle only, strtcnt rises the cycle after release, and the first changecolor comes 8 cycles later.
REQ-033 SHALL cover: staying in RUN for 40 cycles -> changecolor every 8 cycles, and color_idx sequence 1,2,3,0,1.
REQ-034 SHALL cover: speed_btn pulsed once in RUN -> cnt restarts, period becomes 4; pulsed twice more -> period 2, then speedlvl wraps to 0 and period returns to 8.
REQ-035 SHALL cover: loop_btn press/release in RUN -> DISARM then IDLE, strtcnt=0, color_idx held, and no further changecolor.
REQ-036 SHALL cover: go=1 for 1 cycle in IDLE and in RUN -> simgo and clr high that cycle, with color_idx unchanged.
REQ-037 SHALL cover: reset asserted at cnt=5 in RUN -> next cycle state=IDLE, color_idx=0, speedlvl=0, led=0; repeat with and without LOOP_SEQ_DEBUG_LED_EN.

Source files
------------

// File: rtl/loop_seq_ctrl.sv
// Loop/step sequencer: a single go steps once, loop_btn press/release toggles free-running stepping, speed_btn cycles the step period.
// Latency: outputs are combinational from the current state and inputs; state, counter, speed and color update on the next clk edge.
// Backpressure: none; button inputs are levels sampled every cycle. Macro LOOP_SEQ_DEBUG_LED_EN enables the debug led outputs.
module loop_seq_ctrl #(
    parameter int CNT_W      = 26,
    parameter int BASE_DELAY = 50000000,
    parameter int NUM_SPEEDS = 3,
    parameter int NUM_COLORS = 4,
    localparam int SPD_W     = ($clog2(NUM_SPEEDS) > 1) ? $clog2(NUM_SPEEDS) : 1,
    localparam int COL_W     = $clog2(NUM_COLORS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             loop_btn,
    input  logic             speed_btn,
    output logic             simgo,
    output logic             clr,
    output logic             strtcnt,
    output logic             changecolor,
    output logic [COL_W-1:0] color_idx,
    output logic [SPD_W-1:0] speedlvl,
    output logic [2:0]       led
);

    // Press/release pairs: IDLE -press-> ARM -release-> RUN -press-> DISARM -release-> IDLE
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ARM    = 2'd1;
    localparam logic [1:0] RUN    = 2'd2;
    localparam logic [1:0] DISARM = 2'd3;

    localparam logic [CNT_W-1:0] BASE_V = CNT_W'(BASE_DELAY);
    localparam logic [SPD_W-1:0] SPD_MAX = SPD_W'(NUM_SPEEDS - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(NUM_COLORS - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_tc;
    logic             w_tc_hit;
    logic             w_run;
    logic             w_spd_edge;
    logic             w_chg;
    logic             r_speed_btn;
    logic [SPD_W-1:0] r_speedlvl;
    logic [COL_W-1:0] r_color;

    // Each speed level halves the step period
    assign w_tc       = BASE_V >> r_speedlvl;
    assign w_tc_hit   = (r_cnt == (w_tc - CNT_W'(1)));
    assign w_run      = (r_state == RUN);
    assign w_spd_edge = speed_btn & ~r_speed_btn;
    assign w_chg      = w_run & w_tc_hit;

    // Next-state decode; any stray encoding falls back to IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (loop_btn)  w_state_nxt = ARM;
            ARM:     if (!loop_btn) w_state_nxt = RUN;
            RUN:     if (loop_btn)  w_state_nxt = DISARM;
            DISARM:  if (!loop_btn) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Counter only advances while staying in RUN; expiry or a speed change restarts it
    always_comb begin
        w_cnt_nxt = '0;
        if (w_run && (w_state_nxt == RUN) && !w_spd_edge && !w_tc_hit) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    // State, step counter and speed-button history
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_speed_btn <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_speed_btn <= speed_btn;
        end
    end

    // Speed level advances on each speed_btn rising edge in any state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_speedlvl <= '0;
        end else if (w_spd_edge) begin
            r_speedlvl <= (r_speedlvl == SPD_MAX) ? '0 : r_speedlvl + SPD_W'(1);
        end
    end

    // Color advances only on a loop step expiry, never on go
    always_ff @(posedge clk) begin
        if (reset) begin
            r_color <= '0;
        end else if (w_chg) begin
            r_color <= (r_color == COL_MAX) ? '0 : r_color + COL_W'(1);
        end
    end

    assign changecolor = w_chg;
    assign simgo       = w_chg | go | ((r_state == IDLE) & loop_btn);
    assign clr         = simgo;
    assign strtcnt     = w_run;
    assign color_idx   = r_color;
    assign speedlvl    = r_speedlvl;

`ifdef LOOP_SEQ_DEBUG_LED_EN
    assign led = {simgo, w_chg, w_run};
`else
    assign led = 3'b000;
`endif

endmodule
